stack_arbiter: RTL
==================

STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of stack entries.
REQ-002 Parameter DEPTH, default 16, capacity of the attached Stack, in entries.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 rq0_push / rq0_pop  input  1 each  requester 0 operation request, level, held until gnt0 or err0.
REQ-006 rq0_data  input  WIDTH  requester 0 push value.
REQ-007 rq1_push / rq1_pop / rq1_data  input  1/1/WIDTH  requester 1, same rules as requester 0.
REQ-008 gnt0 / gnt1  output  1 each  one-cycle pulse, operation accepted and issued.
REQ-009 err0 / err1  output  1 each  one-cycle pulse, operation rejected.
REQ-010 rd_valid  output  1  one-cycle pulse, popped data valid.
REQ-011 rd_data  output  WIDTH  popped value; rd_id  output  1  requester that owns rd_data.
REQ-012 stk_push / stk_pop  output  1 each  strobes to the Stack, never both high.
REQ-013 stk_value  output  WIDTH  push data to the Stack.
REQ-014 stk_last_pop  input  WIDTH  Stack lastPop, updated by the Stack on the edge that samples stk_pop.
REQ-015 count  output  clog2(DEPTH+1)  current occupancy; full / empty  output  1 each.

Function
REQ-016 FSM states: IDLE, ISSUE, REJECT, CAPTURE.
REQ-017 IDLE: if any request is pending, arbitrate on the edge and go to ISSUE (legal) or REJECT (illegal); otherwise stay in IDLE.
REQ-018 Arbitration: round-robin between requesters; with both requesting, the one not granted or rejected last wins; the pointer updates on both grant and reject.
REQ-019 Illegal request: push while full, pop while empty, or push and pop both high from one requester.
REQ-020 ISSUE lasts one cycle: gntN=1; stk_push or stk_pop=1; stk_value=latched data; count updated ±1 on exit edge.
REQ-021 ISSUE exit: push -> IDLE; pop -> CAPTURE.
REQ-022 CAPTURE lasts one cycle: rd_valid=1, rd_data=stk_last_pop, rd_id=winner; then -> IDLE.
REQ-023 REJECT lasts one cycle: errN=1, no stack strobe, count unchanged; then -> IDLE.
REQ-024 Latency: request visible before edge k -> gnt/err during cycle k+1 -> pop data in cycle k+2; throughput one push per 2 cycles, one pop per 3.
REQ-025 Data and op are latched at the arbitration edge; later request changes do not affect the operation in flight.
REQ-026 full = (count==DEPTH), empty = (count==0), both combinational from count; count never exceeds DEPTH or wraps below 0.
REQ-027 Requests arriving outside IDLE wait, with no loss, no glitching of gnt/err.
REQ-028 Loser of a simultaneous arbitration is served at the next IDLE visit.

Reset
REQ-029 On reset: state=IDLE, count=0, RR pointer favours requester 0; all pulses, strobes, rd_data, rd_id and stk_value = 0.
REQ-030 Reset mid-operation aborts it: no gnt, rd_valid or strobe after reset asserts, and count returns to 0 (the Stack is reset or re-emptied by system convention).

Structure
REQ-031 Shared package stack_pkg holds the state enum, the op encoding (NOP/PUSH/POP), and the WIDTH/DEPTH defaults.
REQ-032 One sub-module, rr_arbiter2: two request inputs, grant vector, pointer register, and an advance input.

Verification
REQ-033 Reset, then rq0_push data=0x05 -> gnt0 one cycle later, stk_push=1, stk_value=0x05, count=1.
REQ-034 Push 0x01,0x02,0x03 then rq1_pop -> gnt1, stk_pop, next cycle rd_valid=1, rd_data=0x03, rd_id=1, count=2.
REQ-035 Both push together from reset (0xA0 and 0xB0) -> gnt0 first, then gnt1; stack top=0xB0; next simultaneous pair -> requester 1 loses priority to 0 per pointer.
REQ-036 Pop at count=0 -> err pulse, no stk_pop, count stays 0; 17th push at DEPTH=16 -> err, count stays 16, full=1.
REQ-037 rq0_push and rq0_pop both high -> err0, no strobe.
REQ-038 Assert reset during CAPTURE -> rd_valid stays 0, count=0, empty=1, state IDLE.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and defaults for the stack arbiter slice.
package stack_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_REJECT  = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2
    } op_t;

    // A request is issuable only if it is a single op that the stack can take.
    function automatic logic op_legal(input logic push, input logic pop,
                                      input logic full, input logic empty);
        logic ok;
        if (push && pop) begin
            ok = 1'b0;
        end else if (push) begin
            ok = !full;
        end else if (pop) begin
            ok = !empty;
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. ptr_r=1 favours requester 1 on a tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_r;

    // Grant: a lone requester always wins, a tie goes to the favoured side.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            if (ptr_r) begin
                gnt = 2'b10;
            end else begin
                gnt = 2'b01;
            end
        end else begin
            gnt = req;
        end
    end

    // Pointer: after any arbitration, favour the requester that did not win.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr_r <= gnt[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates two requesters onto a single external stack, tracking occupancy.
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rq0_push,
    input  logic                       rq0_pop,
    input  logic [WIDTH-1:0]           rq0_data,
    input  logic                       rq1_push,
    input  logic                       rq1_pop,
    input  logic [WIDTH-1:0]           rq1_data,
    output logic                       gnt0,
    output logic                       gnt1,
    output logic                       err0,
    output logic                       err1,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_id,
    output logic                       stk_push,
    output logic                       stk_pop,
    output logic [WIDTH-1:0]           stk_value,
    input  logic [WIDTH-1:0]           stk_last_pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = DEPTH[CW-1:0];

    state_t           state_r;
    op_t              op_r;
    logic             win_r;
    logic [1:0]       req_s;
    logic [1:0]       arb_gnt_s;
    logic             advance_s;
    logic             sel_push_s;
    logic             sel_pop_s;
    logic [WIDTH-1:0] sel_data_s;
    logic             legal_s;

    assign req_s     = {rq1_push | rq1_pop, rq0_push | rq0_pop};
    assign advance_s = (state_r == ST_IDLE);
    assign full      = (count == CNT_MAX);
    assign empty     = (count == {CW{1'b0}});

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_s),
        .advance (advance_s),
        .gnt     (arb_gnt_s)
    );

    // Route the winning requester's operation and data to the FSM.
    always_comb begin
        sel_push_s = 1'b0;
        sel_pop_s  = 1'b0;
        sel_data_s = {WIDTH{1'b0}};
        if (arb_gnt_s[1]) begin
            sel_push_s = rq1_push;
            sel_pop_s  = rq1_pop;
            sel_data_s = rq1_data;
        end else begin
            sel_push_s = rq0_push;
            sel_pop_s  = rq0_pop;
            sel_data_s = rq0_data;
        end
        legal_s = op_legal(sel_push_s, sel_pop_s, full, empty);
    end

    // The stack updates lastPop on the edge that enters CAPTURE, so the
    // popped value is forwarded while rd_valid is high instead of re-registered.
    assign rd_data = rd_valid ? stk_last_pop : {WIDTH{1'b0}};

    // Main FSM: arbitrate in IDLE, then one-cycle ISSUE/REJECT/CAPTURE phases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            op_r      <= OP_NOP;
            win_r     <= 1'b0;
            count     <= {CW{1'b0}};
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_id     <= 1'b0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            stk_value <= {WIDTH{1'b0}};
        end else begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            rd_valid <= 1'b0;
            stk_push <= 1'b0;
            stk_pop  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s != 2'b00) begin
                        win_r <= arb_gnt_s[1];
                        if (legal_s) begin
                            state_r   <= ST_ISSUE;
                            op_r      <= sel_push_s ? OP_PUSH : OP_POP;
                            gnt0      <= arb_gnt_s[0];
                            gnt1      <= arb_gnt_s[1];
                            stk_push  <= sel_push_s;
                            stk_pop   <= sel_pop_s;
                            stk_value <= sel_data_s;
                        end else begin
                            state_r <= ST_REJECT;
                            op_r    <= OP_NOP;
                            err0    <= arb_gnt_s[0];
                            err1    <= arb_gnt_s[1];
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (op_r == OP_PUSH) begin
                        if (!full) begin
                            count <= count + CNT_ONE;
                        end else begin
                            count <= count;
                        end
                        state_r <= ST_IDLE;
                    end else if (op_r == OP_POP) begin
                        if (!empty) begin
                            count <= count - CNT_ONE;
                        end else begin
                            count <= count;
                        end
                        rd_valid <= 1'b1;
                        rd_id    <= win_r;
                        state_r  <= ST_CAPTURE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REJECT:  state_r <= ST_IDLE;
                ST_CAPTURE: state_r <= ST_IDLE;
                default:    state_r <= ST_IDLE;
            endcase
        end
    end

endmodule
